// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 block sequencer.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_BYTES = 64;

    localparam logic [7:0] PAD_BYTE      = 8'h80;
    localparam logic [5:0] LEN_LIMIT_IDX = 6'd55;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_PAD   = 3'd2,
        S_LEN   = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Trailing 64-bit message length field, in bits.
    function automatic logic [63:0] len_field(input logic [31:0] byte_count);
        return {29'b0, byte_count, 3'b0};
    endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// 64-byte block buffer: byte writes, padding fill, length insert, word reads.
module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [5:0]        wr_idx,
    input  logic [7:0]        wr_byte,
    input  logic              pad_en,
    input  logic [5:0]        pad_idx,
    input  logic              len_en,
    input  logic [63:0]       len_bits,
    input  logic [3:0]        rd_idx,
    output logic [WORD_W-1:0] rd_word
);
    // Byte 0 is the most significant byte of word 0.
    logic [BLOCK_BYTES-1:0][7:0] mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (clr) begin
            mem <= '0;
        end else begin
            for (int p = 0; p < BLOCK_BYTES; p++) begin
                if (pad_en && (6'(p) == pad_idx))
                    mem[p] <= PAD_BYTE;
                else if (pad_en && (6'(p) > pad_idx))
                    mem[p] <= 8'h00;
                else if (wr_en && (6'(p) == wr_idx))
                    mem[p] <= wr_byte;
                else if (len_en && (p >= BLOCK_BYTES - 8))
                    mem[p] <= len_bits[8*(BLOCK_BYTES-1-p) +: 8];
            end
        end
    end

    assign rd_word = {mem[{rd_idx, 2'b00}], mem[{rd_idx, 2'b01}],
                      mem[{rd_idx, 2'b10}], mem[{rd_idx, 2'b11}]};

endmodule

// File: rtl/sha256_block_sequencer.sv
// SHA-256 message block sequencer: packs bytes into 64-byte blocks, appends
// padding and bit length, and streams each block to the compression core.
module sha256_block_sequencer
    import sha256_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msg_start_in,
    input  logic              byte_dv_in,
    input  logic [7:0]        byte_in,
    input  logic              msg_end_in,
    input  logic              core_ready_in,
    input  logic              core_block_done_in,
    output logic              byte_ready_out,
    output logic              word_dv_out,
    output logic [WORD_W-1:0] word_out,
    output logic              first_block_out,
    output logic              last_block_out,
    output logic              busy_out,
    output logic              msg_done_out,
    output logic              drop_err_out
);
    state_t            state, state_nxt;
    logic [31:0]       byte_count;
    logic [5:0]        byte_idx;
    logic [3:0]        word_idx;
    logic              first_flag, last_flag, pending_end, len_pending;
    logic              byte_acc, block_full, issue_go, issue_end;
    logic              buf_clr, buf_pad, buf_len;
    logic [WORD_W-1:0] rd_word;

    assign byte_acc   = (state == S_FILL) && byte_dv_in;
    assign block_full = byte_acc && (byte_idx == 6'(BLOCK_BYTES - 1));
    // Once word 0 has gone out the rest of the block streams regardless of ready.
    assign issue_go   = (state == S_ISSUE) && (core_ready_in || (word_idx != 4'd0));
    assign issue_end  = issue_go && (word_idx == 4'(BLOCK_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (msg_start_in) state_nxt = S_FILL;
            S_FILL: begin
                if (block_full)      state_nxt = S_ISSUE;
                else if (msg_end_in) state_nxt = S_PAD;
            end
            S_PAD:   state_nxt = (byte_idx <= LEN_LIMIT_IDX) ? S_LEN : S_ISSUE;
            S_LEN:   state_nxt = S_ISSUE;
            S_ISSUE: if (issue_end) state_nxt = S_WAIT;
            S_WAIT: begin
                if (core_block_done_in) begin
                    if (len_pending)      state_nxt = S_LEN;
                    else if (pending_end) state_nxt = S_PAD;
                    else if (last_flag)   state_nxt = S_DONE;
                    else                  state_nxt = S_FILL;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count   <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            first_flag   <= 1'b0;
            last_flag    <= 1'b0;
            pending_end  <= 1'b0;
            len_pending  <= 1'b0;
            drop_err_out <= 1'b0;
        end else begin
            drop_err_out <= byte_dv_in && (state != S_FILL);
            case (state)
                S_IDLE: begin
                    if (msg_start_in) begin
                        byte_count  <= '0;
                        byte_idx    <= '0;
                        word_idx    <= '0;
                        first_flag  <= 1'b1;
                        last_flag   <= 1'b0;
                        pending_end <= 1'b0;
                        len_pending <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (byte_acc) begin
                        byte_count <= byte_count + 32'd1;
                        byte_idx   <= byte_idx + 6'd1;
                    end
                    if (block_full && msg_end_in) pending_end <= 1'b1;
                end
                // Length no longer fits: it goes into a following all-zero block.
                S_PAD: if (byte_idx > LEN_LIMIT_IDX) len_pending <= 1'b1;
                S_LEN: last_flag <= 1'b1;
                S_ISSUE: begin
                    if (issue_go) begin
                        word_idx <= word_idx + 4'd1;
                        if (issue_end) first_flag <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (core_block_done_in) begin
                        if (len_pending) begin
                            len_pending <= 1'b0;
                        end else begin
                            pending_end <= 1'b0;
                            byte_idx    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        byte_ready_out  = (state == S_FILL);
        busy_out        = (state != S_IDLE);
        word_dv_out     = issue_go;
        word_out        = issue_go ? rd_word : '0;
        first_block_out = (state == S_ISSUE) && first_flag;
        last_block_out  = (state == S_ISSUE) && last_flag;
        msg_done_out    = (state == S_DONE);
        buf_clr         = ((state == S_IDLE) && msg_start_in) ||
                          ((state == S_WAIT) && core_block_done_in && len_pending);
        buf_pad         = (state == S_PAD);
        buf_len         = (state == S_LEN);
    end

    sha256_blk_buf u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (buf_clr),
        .wr_en    (byte_acc),
        .wr_idx   (byte_idx),
        .wr_byte  (byte_in),
        .pad_en   (buf_pad),
        .pad_idx  (byte_idx),
        .len_en   (buf_len),
        .len_bits (len_field(byte_count)),
        .rd_idx   (word_idx),
        .rd_word  (rd_word)
    );

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: issued words are compared against the
// standard SHA-256 padded message built from the bytes sent.
module tb_sha256_block_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        msg_start_in = 1'b0, byte_dv_in = 1'b0, msg_end_in = 1'b0;
    logic        core_ready_in = 1'b0, core_block_done_in = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready_out, word_dv_out, first_block_out, last_block_out;
    logic        busy_out, msg_done_out, drop_err_out;
    logic [31:0] word_out;

    int vectors = 0;
    int miscompares = 0;
    int n, wcnt;
    bit seen;

    sha256_block_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .msg_start_in       (msg_start_in),
        .byte_dv_in         (byte_dv_in),
        .byte_in            (byte_in),
        .msg_end_in         (msg_end_in),
        .core_ready_in      (core_ready_in),
        .core_block_done_in (core_block_done_in),
        .byte_ready_out     (byte_ready_out),
        .word_dv_out        (word_dv_out),
        .word_out           (word_out),
        .first_block_out    (first_block_out),
        .last_block_out     (last_block_out),
        .busy_out           (busy_out),
        .msg_done_out       (msg_done_out),
        .drop_err_out       (drop_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {25'd0, byte_ready_out, word_dv_out, word_out, first_block_out,
                last_block_out, busy_out, msg_done_out, drop_err_out};
    endfunction

    // kind: 0 random bytes, 1 zero bytes, 2 "abc..." ascending from 0x61
    task automatic run_msg(input int kind, input int len, input bit end_last,
                           input int hold0, input bit poke);
        logic [7:0]  m[$];
        logic [7:0]  p[$];
        logic [31:0] ew[$];
        logic [63:0] bits;
        int sent, widx, nexp, inblk, wait_cnt, done_dly;
        bit ended, finished, poked, last_dv, last_rdy, rdy_now;

        for (int i = 0; i < len; i++) begin
            case (kind)
                0:       m.push_back(8'($urandom));
                1:       m.push_back(8'h00);
                default: m.push_back(8'h61 + 8'(i));
            endcase
        end
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(len) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        for (int i = 0; i < p.size(); i += 4) ew.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        nexp = ew.size();

        @(negedge clk);
        msg_start_in = 1'b1; byte_dv_in = 1'b0; msg_end_in = 1'b0;
        core_block_done_in = 1'b0; core_ready_in = 1'b0;
        sent = 0; widx = 0; inblk = 0; wait_cnt = hold0; done_dly = 0;
        ended = 0; finished = 0; poked = 0; last_dv = 0; last_rdy = 0;

        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            msg_start_in = 1'b0; byte_dv_in = 1'b0; msg_end_in = 1'b0; core_block_done_in = 1'b0;
            rdy_now = byte_ready_out;
            if (byte_ready_out && !ended) begin
                if (sent < len && $urandom_range(3) != 0) begin
                    byte_dv_in = 1'b1; byte_in = m[sent]; sent++;
                    if (sent == len && end_last) begin msg_end_in = 1'b1; ended = 1; end
                end else if (sent == len) begin
                    msg_end_in = 1'b1; ended = 1;
                end else begin
                    // stray controls that must be ignored while filling
                    msg_start_in       = ($urandom_range(7) == 0);
                    core_block_done_in = ($urandom_range(7) == 0);
                end
            end
            if (inblk == 16) begin
                core_ready_in = 1'b0;
                if (poke && !poked) begin byte_dv_in = 1'b1; poked = 1; end
                if (done_dly == 0) begin
                    core_block_done_in = 1'b1; inblk = 0; wait_cnt = $urandom_range(3);
                end else done_dly--;
            end else if (wait_cnt > 0) begin
                core_ready_in = 1'b0;
                if (!byte_ready_out && busy_out) wait_cnt--;
            end else begin
                core_ready_in = 1'b1;
            end

            #1;
            chk("drop_err", 64'(drop_err_out), 64'(last_dv && !last_rdy));
            last_dv = byte_dv_in; last_rdy = rdy_now;
            if (inblk == 0 && !core_ready_in) chk("hold_no_word", 64'(word_dv_out), 64'd0);
            if (inblk > 0 && inblk < 16)      chk("no_gap", 64'(word_dv_out), 64'd1);
            if (word_dv_out) begin
                if (widx < nexp) begin
                    chk($sformatf("word%0d", widx), 64'(word_out), 64'(ew[widx]));
                    chk("first_flag", 64'(first_block_out), 64'(widx < 16));
                    chk("last_flag", 64'(last_block_out), 64'(widx >= nexp - 16));
                end else begin
                    chk("extra_word", 64'(word_dv_out), 64'd0);
                end
                widx++; inblk++;
                if (inblk == 16) done_dly = $urandom_range(1, 4);
            end
            if (msg_done_out) finished = 1;
        end
        chk("msg_done_seen", 64'(finished), 64'd1);
        chk("word_count", 64'(widx), 64'(nexp));
        @(negedge clk); #1;
        chk("done_pulse_len", 64'(msg_done_out), 64'd0);
        chk("idle_after_done", 64'(busy_out), 64'd0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk("reset_outputs", outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; core_ready_in = 1'b1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("idle_after_reset", 64'({word_dv_out, busy_out}), 64'd0);
        end

        run_msg(2, 3, 0, 12, 1);   // "abc", stalled core, byte dropped while waiting
        run_msg(0, 0, 0, 0, 0);    // empty message
        run_msg(1, 56, 0, 2, 0);   // length spills into a second block
        run_msg(0, 64, 1, 1, 0);   // end with the 64th byte
        run_msg(0, 55, 1, 0, 0);   // largest single-block message
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(140);
            run_msg(0, n, (n != 0) && ($urandom_range(1) == 1), $urandom_range(6),
                    $urandom_range(1) == 1);
        end

        // reset asserted while word 7 of a block is on the bus
        @(negedge clk);
        msg_start_in = 1'b1; core_ready_in = 1'b1; byte_dv_in = 1'b0;
        @(negedge clk);
        msg_start_in = 1'b0; byte_dv_in = 1'b1; byte_in = 8'h41; msg_end_in = 1'b1;
        @(negedge clk);
        byte_dv_in = 1'b0; msg_end_in = 1'b0;
        seen = 0; wcnt = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk); #1;
            if (word_dv_out) begin
                if (wcnt == 7) seen = 1;
                else wcnt++;
            end
        end
        chk("reach_word7", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1 chk("async_clear", outs(), 64'd0);
        @(negedge clk); #1;
        chk("reset_mid_issue", outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk("no_word_after_reset", 64'({word_dv_out, busy_out}), 64'd0);
        end

        run_msg(0, 20, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
